bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/rv32i_bus_pkg.sv | 19 +
 rtl/starve_counter.sv | 40 ++++
 rtl/bus_arbiter.sv | 123 ++++++++++++
 tb/tb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_bus_pkg.sv
// Shared bus types: arbiter FSM states, transaction owner, and default widths
// used by the arbiter and the address decoder.
package rv32i_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 14;
    localparam int unsigned BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } bus_owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive fetch losses; sat tells the arbiter that
// fetch must win the next arbitration.
module starve_counter #(
    parameter int unsigned MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (instruction fetch vs load/store) with one
// outstanding transaction, ls priority, and fetch starvation protection.
module bus_arbiter
    import rv32i_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = BUS_ADDR_W,
    parameter int unsigned DATA_W     = BUS_DATA_W,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wen,
    output logic              bus_ren,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_e        state_q, state_d;
    bus_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_sat;
    logic ls_win;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

    // Arbitration, next state, and bus/handshake decode from the current state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        ls_rvalid  = 1'b0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
        ls_win     = ls_req && !(if_req && starve_sat);

        unique case (state_q)
            IDLE: begin
                // A fetch that loses counts as a starvation step; anything
                // else seen in IDLE (fetch wins, or no fetch request) clears.
                starve_inc = if_req && ls_win;
                starve_clr = !(if_req && ls_win);
                if (if_req || ls_req) begin
                    owner_d = ls_win ? OWN_LS : OWN_IF;
                    addr_d  = ls_win ? ls_addr : if_addr;
                    we_d    = ls_win && ls_we;
                    wdata_d = ls_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if_gnt  = (owner_q == OWN_IF);
                ls_gnt  = (owner_q == OWN_LS);
                bus_wen = we_q;
                bus_ren = !we_q;
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                if_rvalid = (owner_q == OWN_IF);
                ls_rvalid = (owner_q == OWN_LS);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign if_rdata  = bus_rdata;
    assign ls_rdata  = bus_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_bus_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic [AW-1:0] bus_addr;
    logic          bus_wen;
    logic          bus_ren;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .bus_addr  (bus_addr),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: cycles elapsed since the accepting edge and
    // the occupancy of the transaction (2 for a store, 3 for a read).
    int            m_since  = 0;
    int            m_occ    = 0;
    bit            m_own_ls = 1'b0;
    bit            m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    int            m_starve = 0;
    bit            m_valid  = 1'b0;
    bit            m_ls_wins;

    always @(posedge clk) begin
        if (rst) begin
            m_since  = 0;
            m_starve = 0;
            m_addr   = '0;
            m_wdata  = '0;
            m_we     = 1'b0;
            m_own_ls = 1'b0;
            m_valid  = 1'b1;
        end else if (m_since == 0) begin
            if (if_req || ls_req) begin
                m_ls_wins = ls_req && !(if_req && m_starve == SM);
                m_own_ls  = m_ls_wins;
                m_addr    = m_ls_wins ? ls_addr : if_addr;
                m_we      = m_ls_wins && ls_we;
                m_wdata   = ls_wdata;
                m_occ     = m_we ? 2 : 3;
                m_since   = 1;
                if (if_req && m_ls_wins) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
                else                     m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else begin
            m_since++;
            if (m_since == m_occ) m_since = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("if_gnt",    64'(if_gnt),    64'(m_since == 1 && !m_own_ls));
            check("ls_gnt",    64'(ls_gnt),    64'(m_since == 1 &&  m_own_ls));
            check("bus_ren",   64'(bus_ren),   64'(m_since == 1 && !m_we));
            check("bus_wen",   64'(bus_wen),   64'(m_since == 1 &&  m_we));
            check("if_rvalid", 64'(if_rvalid), 64'(m_since == 2 && !m_own_ls));
            check("ls_rvalid", 64'(ls_rvalid), 64'(m_since == 2 &&  m_own_ls));
            check("bus_addr",  64'(bus_addr),  64'(m_addr));
            if (m_since == 1 && m_we) check("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
            check("if_rdata",  64'(if_rdata),  64'(bus_rdata));
            check("ls_rdata",  64'(ls_rdata),  64'(bus_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_ls[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int w;
        int ngnt;
        int nrv;
        int last;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; bus_rdata = '0;
        tick(); tick();
        check("reset_gnt",  64'({if_gnt, ls_gnt}), 64'(0));
        check("reset_en",   64'({bus_ren, bus_wen}), 64'(0));
        check("reset_addr", 64'(bus_addr), 64'(0));
        rst = 1'b0;

        // Lone fetch
        if_req = 1'b1; if_addr = 14'h0010; bus_rdata = 32'hDEADBEEF;
        tick();
        check("fetch_ren",  64'(bus_ren), 64'(1));
        check("fetch_addr", 64'(bus_addr), 64'(14'h0010));
        check("fetch_gnt",  64'(if_gnt), 64'(1));
        if_req = 1'b0;
        tick();
        check("fetch_rvalid", 64'(if_rvalid), 64'(1));
        check("fetch_rdata",  64'(if_rdata), 64'(32'hDEADBEEF));
        tick();

        // Store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 14'h2001; ls_wdata = 32'h5A;
        tick();
        check("store_wen",   64'(bus_wen), 64'(1));
        check("store_ren",   64'(bus_ren), 64'(0));
        check("store_addr",  64'(bus_addr), 64'(14'h2001));
        check("store_wdata", 64'(bus_wdata), 64'(32'h5A));
        check("store_gnt",   64'(ls_gnt), 64'(1));
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        check("store_no_rvalid", 64'(ls_rvalid), 64'(0));
        check("store_wen_once",  64'(bus_wen), 64'(0));
        if_req = 1'b1; if_addr = 14'h0010;
        tick();
        check("store_idle_after2", 64'(bus_ren), 64'(1));
        if_req = 1'b0;
        tick(); tick();

        // Contention: starting from a cleared starvation count
        rst = 1'b1; tick(); rst = 1'b0;
        if_req = 1'b1; if_addr = 14'h0100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'h3000;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!(if_gnt || ls_gnt) && w < 10);
            if (!(if_gnt || ls_gnt)) begin
                check($sformatf("contention_timeout_%0d", k), 64'(w), 64'(0));
            end else begin
                check($sformatf("contention_ls_gnt_%0d", k), 64'(ls_gnt), 64'(exp_ls[k]));
                check($sformatf("contention_addr_%0d", k), 64'(bus_addr),
                      exp_ls[k] ? 64'(14'h3000) : 64'(14'h0100));
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick(); tick(); tick();

        // Back-to-back loads
        ngnt = 0; nrv = 0; last = -1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'h0040;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ls_gnt) begin
                if (last >= 0) check("b2b_spacing", 64'(i - last), 64'(3));
                last = i;
                ngnt++;
            end
            if (ls_rvalid) nrv++;
        end
        ls_req = 1'b0;
        check("b2b_gnt_count",    64'(ngnt), 64'(4));
        check("b2b_rvalid_count", 64'(nrv), 64'(4));
        tick();

        // Reset during ACCESS of a read
        ls_req = 1'b1; ls_addr = 14'h0008;
        tick();
        check("rstmid_gnt", 64'(ls_gnt), 64'(1));
        rst = 1'b1; ls_req = 1'b0;
        tick();
        check("rstmid_rvalid", 64'({if_rvalid, ls_rvalid}), 64'(0));
        check("rstmid_gnt0",   64'({if_gnt, ls_gnt}), 64'(0));
        check("rstmid_en",     64'({bus_ren, bus_wen}), 64'(0));
        check("rstmid_addr",   64'(bus_addr), 64'(0));
        rst = 1'b0;
        tick();
        check("rstmid_still_no_rvalid", 64'(ls_rvalid), 64'(0));

        // Input change during ACCESS
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 14'h0004;
        tick();
        check("hold_addr_access", 64'(bus_addr), 64'(14'h0004));
        ls_addr = 14'h2000; ls_req = 1'b0;
        tick();
        check("hold_addr_resp", 64'(bus_addr), 64'(14'h0004));
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            if_req    = ($urandom_range(0, 3) != 0);
            ls_req    = ($urandom_range(0, 3) != 0);
            ls_we     = $urandom_range(0, 1) == 1;
            if_addr   = AW'($urandom);
            ls_addr   = AW'($urandom);
            ls_wdata  = $urandom;
            bus_rdata = $urandom;
            tick();
        end
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
